serial_burst_collector: RTL and testbench
=========================================

// Module: serial_burst_collector
// PURPOSE
//  Downstream consumer of the serial device's (outvalid, out) bit stream. Packs each valid-bit
//  burst into WIDTH-bit words, tags word length and end-of-burst, and buffers them in a
//  DEPTH-entry FIFO behind a valid/ready port. The device has no backpressure, so FIFO overrun
//  drops words and raises a sticky flag.
// PARAMETERS
//  WIDTH  8  bits per output word (>=2)
//  DEPTH  4  FIFO entries (power of 2, >=2)
// PORTS
//  clk          in   1                    rising-edge clock
//  rst          in   1                    asynchronous, active-low reset (0 = reset)
//  in_valid     in   1                    device outvalid; in_bit is meaningful when 1
//  in_bit       in   1                    device out serial data
//  word_data    out  WIDTH                FIFO head data, right-aligned; first bit at [len-1]
//  word_len     out  $clog2(WIDTH+1)      valid bits in head word, 1..WIDTH
//  word_last    out  1                    head word is the final word of its burst
//  word_valid   out  1                    FIFO not empty
//  word_ready   in   1                    consumer accepts head word when valid & ready
//  fifo_level   out  $clog2(DEPTH+1)      entries stored, 0..DEPTH
//  overflow     out  1                    sticky: a word was dropped
//  busy         out  1                    1 while in COLLECT
// BEHAVIOUR
//  - All state sampled on rising clk; rst=0 clears immediately: every output 0, FIFO empty,
//    shift reg/bit count 0, FSM -> SYNC.
//  - FSM: SYNC, IDLE, COLLECT.
//    SYNC: ignores in_bit; in_valid=0 sampled -> IDLE (no joining a burst already in progress).
//    IDLE: in_valid=1 -> shreg<=in_bit, cnt<=1, -> COLLECT.
//    COLLECT, in_valid=1, cnt<WIDTH: shreg<={shreg,in_bit}, cnt++.
//    COLLECT, in_valid=1, cnt==WIDTH: push {shreg,WIDTH,last=0}; shreg<=in_bit; cnt<=1.
//    COLLECT, in_valid=0: push {shreg,cnt,last=1}; cnt<=0; -> IDLE.
//  - Full words push one edge after their final bit; last is known only then.
//  - Latency: final bit of a word sampled at edge k -> pushed at edge k+1; word_valid=1 after
//    k+1 when FIFO was empty (head outputs come straight from FIFO storage, no extra stage).
//  - Bursts need >=1 idle cycle between them (inherent to the in_valid framing).
//  - Pop on edge with word_valid & word_ready; head advances, next entry visible next cycle.
//  - Push and pop on the same edge: allowed even when full; level unchanged, no overflow.
//  - Push when full with no pop: word discarded, overflow<=1 (held until rst), level stays
//    DEPTH, FSM/shreg continue normally.
//  - Pop when empty: ignored. word_data/len/last = 0 while word_valid=0.
//  - Pointers wrap modulo DEPTH; level computed separately so full/empty are unambiguous.
//  - Reset mid-burst: partial word and all FIFO contents lost; resync via SYNC.
//  - busy=1 exactly in COLLECT.
// TESTING  (WIDTH=8, DEPTH=4, 100 ns clock, in_valid/in_bit driven away from rising edge)
//  1. Release rst with in_valid=1 for 3 cycles, then 0, then burst 1,1 -> no push for the first
//     run; single word data=8'h03 len=2 last=1.
//  2. Burst 1,0,1,1,0,0,1,0 then in_valid=0, ready=1 -> one word 8'hB2 len=8 last=1,
//     word_valid high one cycle after final bit edge.
//  3. 11-bit burst 10110010 101 -> word 8'hB2 len=8 last=0, then 8'h05 len=3 last=1, in order.
//  4. ready=0, five 1-bit bursts (bit=1) -> level=4, overflow=1 after 5th push; ready=1 drains
//     four words 8'h01 len=1 last=1, then word_valid=0; overflow stays 1.
//  5. FIFO full, ready=1 on the edge a new word pushes -> level stays 4, overflow stays 0,
//     order preserved.
//  6. rst=0 after 3 bits of a burst while FIFO holds 2 words -> level=0, word_valid=0,
//     overflow=0, busy=0; remaining burst bits produce no word (SYNC).

Source files
------------

// File: rtl/serial_burst_collector_if.sv
// Word-side handshake of the serial burst collector: FIFO head plus consumer ready.
interface serial_burst_collector_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0]           word_data;
  logic [$clog2(WIDTH+1)-1:0] word_len;
  logic                       word_last;
  logic                       word_valid;
  logic                       word_ready;

  modport master (
    output word_data,
    output word_len,
    output word_last,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_len,
    input  word_last,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/serial_burst_collector.sv
// Packs valid-bit bursts from the serial device into WIDTH-bit words tagged with
// length and end-of-burst, and queues them in a DEPTH-entry FIFO. The device cannot
// be stalled, so a word arriving at a full FIFO is dropped and a sticky flag is set.
module serial_burst_collector #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_bit,
  serial_burst_collector_if.master   word,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       overflow,
  output logic                       busy
);
  localparam int LW = $clog2(WIDTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {S_SYNC, S_IDLE, S_COLLECT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [LW-1:0]    r_cnt;
  logic [LW-1:0]    w_cnt_nxt;
  logic             w_push;
  logic [WIDTH-1:0] w_push_data;
  logic [LW-1:0]    w_push_len;
  logic             w_push_last;

  logic [WIDTH-1:0] r_mem_data [DEPTH];
  logic [LW-1:0]    r_mem_len  [DEPTH];
  logic             r_mem_last [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_level;
  logic             r_overflow;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_wr;

  // Burst framing FSM: decides shift/count updates and when a finished word is pushed
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    w_push_data = r_shreg;
    w_push_len  = r_cnt;
    w_push_last = 1'b0;
    case (r_state)
      S_SYNC: begin
        // Wait for a gap so we never join a burst midway
        if (!in_valid) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (in_valid) begin
          w_shreg_nxt = WIDTH'(in_bit);
          w_cnt_nxt   = LW'(1);
          w_state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (in_valid) begin
          if (r_cnt == LW'(WIDTH)) begin
            // Full word is only known not to be last once another bit arrives
            w_push      = 1'b1;
            w_shreg_nxt = WIDTH'(in_bit);
            w_cnt_nxt   = LW'(1);
          end else begin
            w_shreg_nxt = {r_shreg[WIDTH-2:0], in_bit};
            w_cnt_nxt   = r_cnt + LW'(1);
          end
        end else begin
          w_push      = 1'b1;
          w_push_last = 1'b1;
          w_shreg_nxt = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_SYNC;
    endcase
  end

  // Framing state, shift register and bit count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_SYNC;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_full  = (r_level == CW'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_pop   = !w_empty && word.word_ready;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push
  assign w_wr    = w_push && (!w_full || w_pop);

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + PW'(1);
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      if (w_wr && !w_pop)      r_level <= r_level + CW'(1);
      else if (!w_wr && w_pop) r_level <= r_level - CW'(1);
      if (w_push && !w_wr) r_overflow <= 1'b1;
    end
  end

  // FIFO storage; stale contents are masked at the outputs while empty
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_data[r_wptr] <= w_push_data;
      r_mem_len[r_wptr]  <= w_push_len;
      r_mem_last[r_wptr] <= w_push_last;
    end
  end

  assign word.word_valid = !w_empty;
  assign word.word_data  = w_empty ? '0   : r_mem_data[r_rptr];
  assign word.word_len   = w_empty ? '0   : r_mem_len[r_rptr];
  assign word.word_last  = w_empty ? 1'b0 : r_mem_last[r_rptr];
  assign fifo_level      = r_level;
  assign overflow        = r_overflow;
  assign busy            = (r_state == S_COLLECT);
endmodule

// File: tb/tb_serial_burst_collector.sv
// Self-checking bench for serial_burst_collector (WIDTH=8, DEPTH=4, 100 ns clock).
module tb_serial_burst_collector;
  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_bit;
  logic [2:0] fifo_level;
  logic       overflow;
  logic       busy;

  serial_burst_collector_if #(.WIDTH(8)) wif ();

  serial_burst_collector #(.WIDTH(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .word       (wif.master),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  typedef struct {
    int          n;
    logic [15:0] bits;
    int          nw;
    logic [7:0]  d0;
    int          l0;
    bit          k0;
    logic [7:0]  d1;
    int          l1;
    bit          k1;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic [3:0] l;
    logic       k;
  } exp_t;

  vec_t vt[7];
  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_word(input logic [7:0] d, input int l, input bit k);
    exp_t e;
    e.d = d;
    e.l = 4'(l);
    e.k = k;
    q.push_back(e);
  endtask

  // Bits go out MSB first from bits[n-1]; returns on the negedge that drops in_valid
  task automatic drive_burst(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = bits[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #40;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && (q.size() != 0 || wif.word_valid); i++) @(negedge clk);
    chk("drain_queue_empty", q.size(), 0);
  endtask

  // Scoreboard: every word leaving the FIFO must match the oldest expectation
  always begin
    @(negedge clk);
    #40;
    if (wif.word_valid && wif.word_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_word", {wif.word_data, wif.word_len, wif.word_last}, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("word", {wif.word_data, wif.word_len, wif.word_last}, {e.d, e.l, e.k});
      end
    end
  end

  initial begin
    vt[0] = '{11, 16'h0595, 2, 8'hB2, 8, 1'b0, 8'h05, 3, 1'b1};
    vt[1] = '{ 1, 16'h0000, 1, 8'h00, 1, 1'b1, 8'h00, 0, 1'b0};
    vt[2] = '{16, 16'hA55A, 2, 8'hA5, 8, 1'b0, 8'h5A, 8, 1'b1};
    vt[3] = '{ 9, 16'h01FF, 2, 8'hFF, 8, 1'b0, 8'h01, 1, 1'b1};
    vt[4] = '{ 3, 16'h0005, 1, 8'h05, 3, 1'b1, 8'h00, 0, 1'b0};
    vt[5] = '{ 8, 16'h000F, 1, 8'h0F, 8, 1'b1, 8'h00, 0, 1'b0};
    vt[6] = '{10, 16'h0301, 2, 8'hC0, 8, 1'b0, 8'h01, 2, 1'b1};

    rst            = 1'b0;
    in_valid       = 1'b0;
    in_bit         = 1'b0;
    wif.word_ready = 1'b1;
    #1;
    chk("rst_word_valid", wif.word_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_head", {wif.word_data, wif.word_len, wif.word_last}, 0);

    // Release reset in the middle of a run: that run must be ignored
    @(negedge clk);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #40;
    chk("sync_busy", busy, 0);
    @(negedge clk);
    in_valid = 1'b0;
    after_edge();
    chk("sync_no_push_level", fifo_level, 0);
    chk("sync_no_push_valid", wif.word_valid, 0);
    expect_word(8'h03, 2, 1'b1);
    drive_burst(16'h0003, 2);
    wait_drain();

    // Push latency: word appears one edge after the final bit
    expect_word(8'hB2, 8, 1'b1);
    drive_burst(16'h00B2, 8);
    #40;
    chk("lat_before_push_valid", wif.word_valid, 0);
    chk("lat_busy_final_bit", busy, 1);
    after_edge();
    chk("lat_after_push_valid", wif.word_valid, 1);
    chk("lat_after_push_level", fifo_level, 1);
    chk("lat_idle_busy", busy, 0);
    wait_drain();

    for (int v = 0; v < 7; v++) begin
      expect_word(vt[v].d0, vt[v].l0, vt[v].k0);
      if (vt[v].nw > 1) expect_word(vt[v].d1, vt[v].l1, vt[v].k1);
      drive_burst(vt[v].bits, vt[v].n);
      wait_drain();
    end
    chk("idle_head_zero", {wif.word_valid, wif.word_data, wif.word_len, wif.word_last}, 0);

    // Overrun: the fifth word is dropped and overflow sticks
    @(negedge clk);
    wif.word_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_word(8'h01, 1, 1'b1);
      drive_burst(16'h0001, 1);
      after_edge();
      if (i == 3) begin
        chk("full_level", fifo_level, 4);
        chk("full_no_overflow", overflow, 0);
      end
    end
    chk("ovf_level", fifo_level, 4);
    chk("ovf_flag", overflow, 1);
    @(negedge clk);
    wif.word_ready = 1'b1;
    wait_drain();
    chk("ovf_drained_valid", wif.word_valid, 0);
    chk("ovf_sticky", overflow, 1);

    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst2_overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b1;

    // Full FIFO with a pop on the push edge: nothing is dropped
    wif.word_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      expect_word(8'(i), 3, 1'b1);
      drive_burst(16'(i), 3);
    end
    after_edge();
    chk("pp_full_level", fifo_level, 4);
    expect_word(8'h05, 3, 1'b1);
    drive_burst(16'h0005, 3);
    wif.word_ready = 1'b1;
    after_edge();
    chk("pp_level", fifo_level, 4);
    chk("pp_overflow", overflow, 0);
    wait_drain();
    chk("pp_overflow_end", overflow, 0);

    // Reset mid-burst with two words queued
    wif.word_ready = 1'b0;
    expect_word(8'h02, 2, 1'b1);
    drive_burst(16'h0002, 2);
    expect_word(8'h07, 3, 1'b1);
    drive_burst(16'h0007, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = 1'(i);
    end
    @(negedge clk);
    chk("mid_level_before", fifo_level, 2);
    chk("mid_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_valid", wif.word_valid, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_busy", busy, 0);
    q.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b1;
      in_bit   = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_bit   = 1'b0;
    after_edge();
    chk("mid_tail_level", fifo_level, 0);
    chk("mid_tail_valid", wif.word_valid, 0);
    wif.word_ready = 1'b1;
    expect_word(8'h06, 3, 1'b1);
    drive_burst(16'h0006, 3);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
